// File: rtl/etb_tim_route_if.sv
// APB slave bus for etb_tim_route.
// Signals: psel/penable/pwrite control, paddr byte address, pwdata write data,
// prdata read data (driven by the slave). Zero-wait-state: no pready.
interface etb_tim_route_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;

  modport master (output psel, penable, pwrite, paddr, pwdata, input prdata);
  modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata);
endinterface

// File: rtl/etb_tim_route.sv
// etb_tim_route: event-to-timer trigger router.
// Four channels each pick one of eight level event sources (rising edge) or a
// software trigger, and emit a one-cycle pulse to the timer block.
// Ports:
//   pclk, preset          clock, synchronous active-high reset
//   apb (slave)           APB register access, zero-wait-state
//   evt_in[7:0]           level event sources
//   etb_tim1/2_trig_en_*  trigger pulses, channel 0..3 = tim1_on, tim1_off, tim2_on, tim2_off
//   etb_intr              registered interrupt, |(STATUS & INT_MASK)
// Registers (word address): 0x00 CH_EN, 0x04..0x10 SEL0..3, 0x14 SW_TRIG (WO),
//   0x18 STATUS (W1C, bit4 = on/off conflict), 0x1C INT_MASK.

// Per-channel request: selected edge gated by enable, OR'd with software trigger.
module etb_tim_route_ch #(
  parameter int SEL_W = 3
) (
  input  logic                  en,
  input  logic [SEL_W-1:0]      sel,
  input  logic [2**SEL_W-1:0]   evt_edge,
  input  logic                  sw,
  output logic                  req
);
  assign req = (en & evt_edge[sel]) | sw;
endmodule

module etb_tim_route (
  input  logic                pclk,
  input  logic                preset,
  etb_tim_route_if.slave      apb,
  input  logic [7:0]          evt_in,
  output logic                etb_tim1_trig_en_on,
  output logic                etb_tim1_trig_en_off,
  output logic                etb_tim2_trig_en_on,
  output logic                etb_tim2_trig_en_off,
  output logic                etb_intr
);
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 3;
  localparam int EVT_W  = 2**SEL_W;

  logic [NUM_CH-1:0]             ch_en;
  logic [NUM_CH-1:0][SEL_W-1:0]  sel;
  logic [4:0]                    status;
  logic [4:0]                    int_mask;
  logic [EVT_W-1:0]              evt_q;
  logic [NUM_CH-1:0]             trig;
  logic                          intr_q;

  logic [5:0]        word;
  logic              wr;
  logic [EVT_W-1:0]  evt_edge;
  logic [NUM_CH-1:0] sw_req, req, fire;
  logic              conflict;
  logic [4:0]        st_set, st_clr;
  logic [31:0]       rdata;
  logic              unused_bits;

  assign word        = apb.paddr[7:2];
  assign wr          = apb.psel & apb.penable & apb.pwrite;
  assign evt_edge    = evt_in & ~evt_q;
  assign unused_bits = ^{apb.pwdata[31:8], apb.paddr[1:0]};

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      assign sw_req[g] = wr & (word == 6'h05) & apb.pwdata[g];
      etb_tim_route_ch #(.SEL_W(SEL_W)) u_ch (
        .en       (ch_en[g]),
        .sel      (sel[g]),
        .evt_edge (evt_edge),
        .sw       (sw_req[g]),
        .req      (req[g])
      );
    end
  endgenerate

  // On/off for the same timer together: off wins, on is dropped, flag conflict.
  assign fire     = {req[3], req[2] & ~req[3], req[1], req[0] & ~req[1]};
  assign conflict = (req[0] & req[1]) | (req[2] & req[3]);
  assign st_set   = {conflict, fire};
  assign st_clr   = (wr && word == 6'h06) ? apb.pwdata[4:0] : 5'h0;

  always_ff @(posedge pclk) begin
    if (preset) begin
      ch_en    <= '0;
      sel      <= '0;
      status   <= '0;
      int_mask <= '0;
      evt_q    <= '0;
      trig     <= '0;
      intr_q   <= 1'b0;
    end else begin
      evt_q  <= evt_in;
      trig   <= fire;
      // Set has priority over a concurrent W1C.
      status <= (status & ~st_clr) | st_set;
      intr_q <= |(status & int_mask);
      if (wr && word == 6'h00) ch_en    <= apb.pwdata[NUM_CH-1:0];
      if (wr && word == 6'h07) int_mask <= apb.pwdata[4:0];
      for (int n = 0; n < NUM_CH; n++)
        if (wr && word == 6'(n + 1)) sel[n] <= apb.pwdata[SEL_W-1:0];
    end
  end

  always_comb begin
    rdata = '0;
    if (apb.psel && !apb.pwrite) begin
      case (word)
        6'h00:   rdata = {28'h0, ch_en};
        6'h01:   rdata = {29'h0, sel[0]};
        6'h02:   rdata = {29'h0, sel[1]};
        6'h03:   rdata = {29'h0, sel[2]};
        6'h04:   rdata = {29'h0, sel[3]};
        6'h06:   rdata = {27'h0, status};
        6'h07:   rdata = {27'h0, int_mask};
        default: rdata = '0;
      endcase
    end
  end

  assign apb.prdata           = rdata;
  assign etb_tim1_trig_en_on  = trig[0];
  assign etb_tim1_trig_en_off = trig[1];
  assign etb_tim2_trig_en_on  = trig[2];
  assign etb_tim2_trig_en_off = trig[3];
  assign etb_intr             = intr_q;
endmodule

// File: tb/tb_etb_tim_route.sv
module tb_etb_tim_route;
  logic       pclk = 1'b0;
  logic       preset;
  logic [7:0] evt_in;
  logic       t1_on, t1_off, t2_on, t2_off, intr;

  etb_tim_route_if apb ();

  etb_tim_route dut (
    .pclk                 (pclk),
    .preset               (preset),
    .apb                  (apb),
    .evt_in               (evt_in),
    .etb_tim1_trig_en_on  (t1_on),
    .etb_tim1_trig_en_off (t1_off),
    .etb_tim2_trig_en_on  (t2_on),
    .etb_tim2_trig_en_off (t2_off),
    .etb_intr             (intr)
  );

  always #5 pclk = ~pclk;

  localparam logic [1:0] IDL = 2'd0, WR = 2'd1, RD = 2'd2;

  typedef struct {
    logic        rst;
    logic [7:0]  evt;
    logic [1:0]  op;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  trig;   // {tim2_off, tim2_on, tim1_off, tim1_on} after the edge
    logic        intr;   // etb_intr after the edge
    logic [31:0] rd;     // prdata in the drive cycle
  } vec_t;

  typedef struct {
    logic [3:0] trig;
    logic       intr;
    string      nm;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(input logic rst, input logic [7:0] evt, input logic [1:0] op,
                              input logic [7:0] addr, input logic [31:0] data,
                              input logic [3:0] trig, input logic intr, input logic [31:0] rd);
    vec_t v;
    v.rst = rst; v.evt = evt; v.op = op; v.addr = addr; v.data = data;
    v.trig = trig; v.intr = intr; v.rd = rd;
    return v;
  endfunction

  task automatic step(input vec_t v, input string nm);
    exp_t e;
    logic [3:0] got;
    preset      = v.rst;
    evt_in      = v.evt;
    apb.psel    = (v.op != IDL);
    apb.penable = (v.op != IDL);
    apb.pwrite  = (v.op == WR);
    apb.paddr   = v.addr;
    apb.pwdata  = v.data;
    #1;
    n_vec++;
    if (apb.prdata !== v.rd) begin
      n_miss++;
      $display("FAIL %s prdata got %h want %h", nm, apb.prdata, v.rd);
    end
    sb.push_back('{v.trig, v.intr, nm});
    @(posedge pclk);
    #1;
    if (sb.size() == 0) begin
      n_miss++;
      $display("FAIL %s scoreboard empty", nm);
    end else begin
      e   = sb.pop_front();
      got = {t2_off, t2_on, t1_off, t1_on};
      n_vec++;
      if (got !== e.trig) begin
        n_miss++;
        $display("FAIL %s trig got %b want %b", e.nm, got, e.trig);
      end
      n_vec++;
      if (intr !== e.intr) begin
        n_miss++;
        $display("FAIL %s intr got %b want %b", e.nm, intr, e.intr);
      end
    end
  endtask

  initial begin
    // Reset state: outputs zero, every register reads zero.
    step(mk(1, 8'h00, IDL, 8'h00, 0, 4'h0, 0, 0), "rst0");
    step(mk(1, 8'h00, IDL, 8'h00, 0, 4'h0, 0, 0), "rst1");
    for (int a = 0; a < 8; a++)
      step(mk(0, 8'h00, RD, 8'(a * 4), 0, 4'h0, 0, 0), $sformatf("rst_rd%0d", a));

    // Main table.
    tbl.push_back(mk(0, 8'h00, WR,  8'h00, 32'h1,  4'h0, 0, 0));   // CH_EN=1
    tbl.push_back(mk(0, 8'h00, WR,  8'h04, 32'h3,  4'h0, 0, 0));   // SEL0=3
    tbl.push_back(mk(0, 8'h08, IDL, 8'h00, 0,      4'h1, 0, 0));   // edge evt[3]
    for (int k = 0; k < 9; k++)
      tbl.push_back(mk(0, 8'h08, IDL, 8'h00, 0,    4'h0, 0, 0));   // held high
    tbl.push_back(mk(0, 8'h00, IDL, 8'h00, 0,      4'h0, 0, 0));
    tbl.push_back(mk(0, 8'h08, IDL, 8'h00, 0,      4'h1, 0, 0));   // 1-cycle pulse
    tbl.push_back(mk(0, 8'h00, IDL, 8'h00, 0,      4'h0, 0, 0));
    tbl.push_back(mk(0, 8'h08, IDL, 8'h00, 0,      4'h1, 0, 0));   // second pulse
    tbl.push_back(mk(0, 8'h00, IDL, 8'h00, 0,      4'h0, 0, 0));
    tbl.push_back(mk(0, 8'h00, RD,  8'h18, 0,      4'h0, 0, 32'h01));
    tbl.push_back(mk(0, 8'h00, WR,  8'h00, 32'h3,  4'h0, 0, 0));   // CH_EN=3
    tbl.push_back(mk(0, 8'h00, WR,  8'h04, 32'h5,  4'h0, 0, 0));   // SEL0=5
    tbl.push_back(mk(0, 8'h00, WR,  8'h08, 32'h5,  4'h0, 0, 0));   // SEL1=5
    tbl.push_back(mk(0, 8'h00, WR,  8'h18, 32'h1F, 4'h0, 0, 0));   // clear STATUS
    tbl.push_back(mk(0, 8'h00, WR,  8'h1C, 32'h10, 4'h0, 0, 0));   // INT_MASK=0x10
    tbl.push_back(mk(0, 8'h20, IDL, 8'h00, 0,      4'h2, 0, 0));   // conflict: off only
    tbl.push_back(mk(0, 8'h20, RD,  8'h18, 0,      4'h0, 1, 32'h12));
    tbl.push_back(mk(0, 8'h00, IDL, 8'h00, 0,      4'h0, 1, 0));
    tbl.push_back(mk(0, 8'h00, WR,  8'h00, 32'h0,  4'h0, 1, 0));   // CH_EN=0
    tbl.push_back(mk(0, 8'h00, WR,  8'h18, 32'h1F, 4'h0, 1, 0));
    tbl.push_back(mk(0, 8'h00, IDL, 8'h00, 0,      4'h0, 0, 0));
    tbl.push_back(mk(0, 8'h00, WR,  8'h14, 32'h0C, 4'h8, 0, 0));   // SW_TRIG conflict
    tbl.push_back(mk(0, 8'h00, RD,  8'h18, 0,      4'h0, 1, 32'h18));
    tbl.push_back(mk(0, 8'h00, RD,  8'h14, 0,      4'h0, 1, 0));   // SW_TRIG reads 0
    tbl.push_back(mk(0, 8'h00, WR,  8'h18, 32'h1F, 4'h0, 1, 0));
    tbl.push_back(mk(0, 8'h00, WR,  8'h1C, 32'h01, 4'h0, 0, 0));   // INT_MASK=1
    tbl.push_back(mk(0, 8'h00, WR,  8'h00, 32'h1,  4'h0, 0, 0));   // CH_EN=1
    tbl.push_back(mk(0, 8'h20, IDL, 8'h00, 0,      4'h1, 0, 0));
    tbl.push_back(mk(0, 8'h00, IDL, 8'h00, 0,      4'h0, 1, 0));
    tbl.push_back(mk(0, 8'h20, WR,  8'h18, 32'h01, 4'h1, 1, 0));   // set+clear same cycle
    tbl.push_back(mk(0, 8'h20, RD,  8'h18, 0,      4'h0, 1, 32'h01));
    tbl.push_back(mk(0, 8'h20, WR,  8'h18, 32'h01, 4'h0, 1, 0));   // clear alone
    tbl.push_back(mk(0, 8'h20, IDL, 8'h00, 0,      4'h0, 0, 0));   // intr falls
    tbl.push_back(mk(0, 8'hA0, IDL, 8'h00, 0,      4'h0, 0, 0));   // unselected edge
    tbl.push_back(mk(0, 8'hA0, WR,  8'h04, 32'h7,  4'h0, 0, 0));   // SEL0=7 onto high src
    tbl.push_back(mk(0, 8'hA0, IDL, 8'h00, 0,      4'h0, 0, 0));
    tbl.push_back(mk(0, 8'hA0, WR,  8'h0C, 32'h7,  4'h0, 0, 0));   // SEL2=7
    tbl.push_back(mk(0, 8'hA0, WR,  8'h00, 32'h5,  4'h0, 0, 0));   // CH_EN=5
    tbl.push_back(mk(0, 8'h20, IDL, 8'h00, 0,      4'h0, 0, 0));
    tbl.push_back(mk(0, 8'hA0, IDL, 8'h00, 0,      4'h5, 0, 0));   // shared source
    tbl.push_back(mk(0, 8'hA0, RD,  8'h20, 0,      4'h0, 1, 0));   // unmapped
    tbl.push_back(mk(0, 8'hA0, RD,  8'h00, 0,      4'h0, 1, 32'h5));
    tbl.push_back(mk(0, 8'hA0, RD,  8'h04, 0,      4'h0, 1, 32'h7));
    tbl.push_back(mk(0, 8'hA0, RD,  8'h1D, 0,      4'h0, 1, 32'h1)); // addr[1:0] ignored
    foreach (tbl[i]) step(tbl[i], $sformatf("v%0d", i));

    // Reset in the middle of traffic: edge and write in the reset cycle are lost.
    step(mk(0, 8'h00, IDL, 8'h00, 0,      4'h0, 1, 0), "r0");
    step(mk(1, 8'h80, WR,  8'h00, 32'hF,  4'h0, 0, 0), "r1");
    step(mk(1, 8'hFF, IDL, 8'h00, 0,      4'h0, 0, 0), "r2");
    step(mk(0, 8'hFF, RD,  8'h00, 0,      4'h0, 0, 0), "r3");
    step(mk(0, 8'hFF, RD,  8'h04, 0,      4'h0, 0, 0), "r4");
    step(mk(0, 8'hFF, RD,  8'h18, 0,      4'h0, 0, 0), "r5");
    step(mk(0, 8'hFF, RD,  8'h1C, 0,      4'h0, 0, 0), "r6");
    step(mk(0, 8'hFF, WR,  8'h00, 32'hF,  4'h0, 0, 0), "r7");
    step(mk(0, 8'hFF, IDL, 8'h00, 0,      4'h0, 0, 0), "r8");
    step(mk(0, 8'h00, IDL, 8'h00, 0,      4'h0, 0, 0), "r9");
    step(mk(0, 8'hFF, IDL, 8'h00, 0,      4'hA, 0, 0), "r10");
    step(mk(0, 8'hFF, RD,  8'h18, 0,      4'h0, 0, 32'h1A), "r11");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/etb_tim_route.md
ETB_TIM_ROUTE -- requirements
Module: etb_tim_route

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 pclk  input  1  APB and logic clock; all state updates on rising edge.
REQ-003 preset  input  1  synchronous active-high reset.
REQ-004 psel, penable, pwrite  input  1 each  APB control; zero-wait-state, no pready.
REQ-005 paddr  input  8  APB byte address; bits[1:0] ignored.
REQ-006 pwdata  input  32  APB write data.
REQ-007 prdata  output  32  APB read data.
REQ-008 evt_in  input  8  level event sources, pclk domain.
REQ-009 etb_tim1_trig_en_on, etb_tim1_trig_en_off, etb_tim2_trig_en_on, etb_tim2_trig_en_off  output  1 each  one-cycle trigger pulses to the timer block; channels 0..3 in that order.
REQ-010 etb_intr  output  1  level interrupt, high while any unmasked STATUS bit is set.

Function
REQ-011 Register map SHALL be: 0x00 CH_EN[3:0] RW; 0x04/0x08/0x0C/0x10 SEL0..SEL3[2:0] RW; 0x14 SW_TRIG[3:0] WO, reads 0; 0x18 STATUS[4:0] W1C; 0x1C INT_MASK[4:0] RW (1 = enabled); other addresses read 0, writes ignored.
REQ-012 Write SHALL occur in the cycle psel & penable & pwrite is high; unused pwdata bits ignored.
REQ-013 prdata SHALL be combinational from paddr when psel & ~pwrite, else 0; unused bits 0.
REQ-014 evt_q[7:0] SHALL register evt_in every cycle; edge[i] = evt_in[i] & ~evt_q[i].
REQ-015 Hardware request for channel n SHALL be CH_EN[n] & edge[SELn].
REQ-016 Software request for channel n SHALL be the APB write to SW_TRIG with pwdata[n]=1, independent of CH_EN.
REQ-017 req[n] = hardware OR software request; combined request SHALL be registered, giving one-cycle output pulse in the cycle after the evt_in rising edge or SW_TRIG write.
REQ-018 Level-high evt_in SHALL produce exactly one pulse per rising edge; a 1-cycle input pulse SHALL also produce exactly one output pulse.
REQ-019 Multiple channels selecting the same source SHALL pulse together.
REQ-020 Conflict: if on and off requests for the same timer (ch0/ch1 or ch2/ch3) coincide, only off SHALL pulse, on suppressed, and STATUS[4] (conflict) SHALL set.
REQ-021 STATUS[n] (n=0..3) SHALL set in the cycle channel n output pulses (registered with it).
REQ-022 STATUS write SHALL clear bits where pwdata=1; simultaneous set and clear of a bit SHALL leave it set.
REQ-023 Changing SELn or CH_EN SHALL take effect on the next cycle's edge evaluation; no pulse SHALL be generated by the change itself.
REQ-024 etb_intr SHALL be registered: |(STATUS & INT_MASK), one cycle after STATUS update.

Reset
REQ-025 On preset high, CH_EN, SELn, STATUS, INT_MASK, evt_q, all trigger outputs and etb_intr SHALL be 0 at the next edge.
REQ-026 Reset SHALL override any concurrent APB write or event; a pending request SHALL be discarded.
REQ-027 evt_q resets to 0, so evt_in held high across reset release SHALL produce one edge in the first cycle after release only if its channel is enabled then (CH_EN resets 0, so no pulse).

Verification
REQ-028 CH_EN=0x1, SEL0=3, evt_in[3] 0->1 at cycle T -> etb_tim1_trig_en_on high only at T+1; STATUS=0x01.
REQ-029 evt_in[3] held high 10 cycles -> exactly one pulse; 1-cycle pulses at T and T+2 -> two pulses at T+1, T+3.
REQ-030 CH_EN=0x3, SEL0=SEL1=5, edge on evt_in[5] -> only etb_tim1_trig_en_off pulses; STATUS=0x12; INT_MASK=0x10 -> etb_intr high one cycle later.
REQ-031 CH_EN=0, write SW_TRIG=0x0C -> both tim2 triggers... conflict: only etb_tim2_trig_en_off pulses next cycle, STATUS=0x18.
REQ-032 STATUS=0x01, write 0x01 same cycle channel 0 fires -> STATUS stays 0x01; later write 0x01 alone -> 0x00, etb_intr falls next cycle.
REQ-033 Assert preset mid-traffic with evt_in=0xFF -> all outputs and registers read 0; no pulses after release until CH_EN written and a new edge occurs.
